// File: rtl/ram_dma_if.sv
// RAM initiator port for ram_dma: CE-gated synchronous write, combinational read.
// The DMA engine takes the master modport; the RAM (or its model) takes the slave side.
interface ram_dma_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 8
);
    logic                  mem_ce;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_data_in;
    logic [WIDTH-1:0]      mem_data_out;

    modport master (
        output mem_ce,
        output mem_addr,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  mem_ce,
        input  mem_addr,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/ram_dma.sv
// Block copy/fill engine driving a single-port RAM; one START moves or fills LEN words, then DONE.
// Optional macro RAM_DMA_ABORT_EN adds an i_abort input that cuts a running transfer short.
module ram_dma #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_op,
    input  logic [ADDR_WIDTH-1:0] i_src,
    input  logic [ADDR_WIDTH-1:0] i_dst,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic [WIDTH-1:0]      i_fill_val,
    output logic                  o_busy,
    output logic                  o_done,
`ifdef RAM_DMA_ABORT_EN
    input  logic                  i_abort,
`endif
    ram_dma_if.master             mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FINISH
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_op;
    logic [WIDTH-1:0]      r_buf;

    logic                  r_ce;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_wdata;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_abort;

`ifdef RAM_DMA_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Outputs are registered together with the state they belong to, so each branch
    // below sets the port values that the next state presents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_op    <= 1'b0;
            r_buf   <= '0;
            r_ce    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ce    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_src   <= i_src;
                        r_dst   <= i_dst;
                        r_count <= i_len;
                        r_op    <= i_op;
                        if (i_op) begin
                            r_buf <= i_fill_val;
                        end
                        if (i_len == '0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else if (i_op) begin
                            r_state <= S_WRITE;
                            r_busy  <= 1'b1;
                            r_ce    <= 1'b1;
                            r_addr  <= i_dst;
                            r_wdata <= i_fill_val;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                            r_addr  <= i_src;
                        end
                    end
                end
                S_READ: begin
                    r_buf <= mem.mem_data_out;
                    r_src <= r_src + 1'b1;
                    if (w_abort) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_WRITE;
                        r_busy  <= 1'b1;
                        r_ce    <= 1'b1;
                        r_addr  <= r_dst;
                        r_wdata <= mem.mem_data_out;
                    end
                end
                S_WRITE: begin
                    r_dst   <= r_dst + 1'b1;
                    r_count <= r_count - 1'b1;
                    if (w_abort || (r_count == CNT_ONE)) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end else if (r_op) begin
                        r_state <= S_WRITE;
                        r_busy  <= 1'b1;
                        r_ce    <= 1'b1;
                        r_addr  <= r_dst + 1'b1;
                        r_wdata <= r_buf;
                    end else begin
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                        r_addr  <= r_src;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign mem.mem_ce      = r_ce;
    assign mem.mem_addr    = r_addr;
    assign mem.mem_data_in = r_wdata;

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: directed scenarios plus random copy/fill transfers against a word-level RAM model.
// Also covers the RAM_DMA_ABORT_EN build when that macro is defined.
module tb_ram_dma;

    logic       clk;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] src;
    logic [7:0] dst;
    logic [8:0] len;
    logic [7:0] fillVal;
    logic       abort;
    logic       busy;
    logic       done;

    logic       plEn;
    logic [7:0] plAddr;
    logic [7:0] plData;

    logic [7:0] ram   [256];
    logic [7:0] model [256];

    int nCompared;
    int nMismatched;

    ram_dma_if #(.ADDR_WIDTH(8), .WIDTH(8)) memIf ();

    ram_dma #(.ADDR_WIDTH(8), .WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_op       (op),
        .i_src      (src),
        .i_dst      (dst),
        .i_len      (len),
        .i_fill_val (fillVal),
        .o_busy     (busy),
        .o_done     (done),
`ifdef RAM_DMA_ABORT_EN
        .i_abort    (abort),
`endif
        .mem        (memIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: the bench preload port wins, otherwise the DUT writes when CE is high.
    always @(posedge clk) begin
        if (plEn) begin
            ram[plAddr] <= plData;
        end else if (memIf.mem_ce) begin
            ram[memIf.mem_addr] <= memIf.mem_data_in;
        end
    end

    assign memIf.mem_data_out = ram[memIf.mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic ramWrite(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        plEn   = 1'b1;
        plAddr = a;
        plData = d;
        @(negedge clk);
        plEn     = 1'b0;
        model[a] = d;
    endtask

    function automatic int ramDiffs();
        int diffs = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== model[i]) diffs++;
        end
        return diffs;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".ce"}, 32'(memIf.mem_ce), 32'd0);
        checkOutput({tag, ".addr"}, 32'(memIf.mem_addr), 32'd0);
        checkOutput({tag, ".wdata"}, 32'(memIf.mem_data_in), 32'd0);
    endtask

    // One transfer: the model predicts the final RAM and the DONE cycle from word counts alone;
    // abortCycle > 0 raises ABORT during that cycle after START.
    task automatic applyStimulus(input string tag, input logic tOp, input logic [7:0] tSrc,
                                 input logic [7:0] tDst, input logic [8:0] tLen,
                                 input logic [7:0] tFill, input int abortCycle);
        int expDone;
        int nWords;
        int doneCycle;
        int busyCycles;
        int ceCycles;
        logic [7:0] a;
        logic [7:0] b;
        expDone = (tLen == 0) ? 1 : (tOp ? int'(tLen) + 1 : 2 * int'(tLen) + 1);
        nWords  = int'(tLen);
        if (abortCycle > 0 && abortCycle < expDone) begin
            expDone = abortCycle + 1;
            nWords  = tOp ? abortCycle : abortCycle / 2;
        end
        for (int i = 0; i < nWords; i++) begin
            a = tDst + 8'(i);
            b = tSrc + 8'(i);
            model[a] = tOp ? tFill : model[b];
        end

        @(negedge clk);
        start = 1'b1; op = tOp; src = tSrc; dst = tDst; len = tLen; fillVal = tFill;
        doneCycle = 0; busyCycles = 0; ceCycles = 0;
        for (int cyc = 1; cyc <= 1100 && doneCycle == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start   = 1'b0;
                op      = 1'($urandom);
                src     = 8'($urandom);
                dst     = 8'($urandom);
                len     = 9'($urandom);
                fillVal = 8'($urandom);
            end
            abort = (cyc == abortCycle);
            if (busy) busyCycles++;
            if (memIf.mem_ce) ceCycles++;
            if (done) begin
                doneCycle = cyc;
                start = 1'b1;
                len   = 9'd3;
            end
        end
        abort = 1'b0;
        checkOutput({tag, ".doneCycle"}, 32'(doneCycle), 32'(expDone));
        checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(expDone - 1));
        checkOutput({tag, ".ceCycles"}, 32'(ceCycles), 32'(nWords));
        @(negedge clk);
        start = 1'b0;
        checkIdle({tag, ".afterDone"});
        checkOutput({tag, ".ramDiffs"}, 32'(ramDiffs()), 32'd0);
    endtask

    initial begin
        int sawDone;
        logic [8:0] rLen;
        nCompared = 0;
        nMismatched = 0;
        rst = 1'b1; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0; fillVal = '0;
        abort = 1'b0; plEn = 1'b0; plAddr = '0; plData = '0;

        repeat (2) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        for (int i = 0; i < 256; i++) ramWrite(8'(i), 8'($urandom));

        ramWrite(8'h10, 8'hA1); ramWrite(8'h11, 8'hB2);
        ramWrite(8'h12, 8'hC3); ramWrite(8'h13, 8'hD4);
        applyStimulus("copy4", 1'b0, 8'h10, 8'h40, 9'd4, 8'h00, 0);
        checkOutput("copy4.word3", 32'(ram[8'h43]), 32'h0000_00D4);

        applyStimulus("fillWrap", 1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A, 0);
        checkOutput("fillWrap.word01", 32'(ram[8'h01]), 32'h0000_005A);

        applyStimulus("len0", 1'b0, 8'h30, 8'h70, 9'd0, 8'h00, 0);

        ramWrite(8'h20, 8'h11); ramWrite(8'h21, 8'h22);
        applyStimulus("overlap", 1'b0, 8'h20, 8'h21, 9'd3, 8'h00, 0);
        checkOutput("overlap.word23", 32'(ram[8'h23]), 32'h0000_0011);

        // Reset lands on the edge closing the second WRITE of a 5-word fill.
        @(negedge clk);
        start = 1'b1; op = 1'b1; dst = 8'h80; len = 9'd5; fillVal = 8'h3C;
        model[8'h80] = 8'h3C;
        model[8'h81] = 8'h3C;
        @(negedge clk);
        start = 1'b1; op = 1'b0; src = 8'h00; dst = 8'h90; len = 9'd7;
        checkOutput("rstMid.addr1", 32'(memIf.mem_addr), 32'h80);
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        checkOutput("rstMid.addr2", 32'(memIf.mem_addr), 32'h81);
        checkOutput("rstMid.ce2", 32'(memIf.mem_ce), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        checkIdle("rstMid.after");
        sawDone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) sawDone++;
        end
        checkOutput("rstMid.noDone", 32'(sawDone), 32'd0);
        checkOutput("rstMid.ramDiffs", 32'(ramDiffs()), 32'd0);

`ifdef RAM_DMA_ABORT_EN
        applyStimulus("abortCopy", 1'b0, 8'h50, 8'hA0, 9'd6, 8'h00, 6);
        applyStimulus("abortFill", 1'b1, 8'h00, 8'hC0, 9'd9, 8'h77, 4);
`endif

        for (int k = 0; k < 24; k++) begin
            rLen = (k % 8 == 7) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 12));
            applyStimulus("random", 1'($urandom), 8'($urandom), 8'($urandom), rLen, 8'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
# ram_dma

Block-transfer engine that acts as the initiator on the single-port RAM interface (CE-gated synchronous write, combinational read). On a one-cycle START it either copies LEN words from SRC to DST or fills LEN words at DST with a constant. It then pulses DONE. It sits between the CPU control logic and the RAM port, so the microprocessor can move or clear memory without per-word instructions.

## Interface
- ADDR_WIDTH, 8, RAM address width; also sets the pointer width.
- WIDTH, 8, RAM data word width.

- CLK  in  1  system clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request strobe, sampled only in IDLE.
- OP  in  1  0 = copy, 1 = fill; latched with START.
- SRC  in  ADDR_WIDTH  copy source base address; latched with START.
- DST  in  ADDR_WIDTH  destination base address; latched with START.
- LEN  in  ADDR_WIDTH+1  word count; 0 = no-op; latched with START.
- FILL_VAL  in  WIDTH  fill constant; latched with START.
- BUSY  out  1  high in READ and WRITE states.
- DONE  out  1  one-cycle completion pulse (FINISH state).
- MEM_CE  out  1  RAM write enable.
- MEM_ADDR  out  ADDR_WIDTH  RAM address.
- MEM_DATA_IN  out  WIDTH  write data to the RAM.
- MEM_DATA_OUT  in  WIDTH  combinational read data from the RAM.

## Operation
- States are IDLE, READ, WRITE and FINISH. Outputs are a Moore decode of the registered state, pointers and data buffer only.
- **IDLE**
  - Outputs are MEM_CE=0, MEM_ADDR=0, MEM_DATA_IN=0, BUSY=0, DONE=0.
  - On START=1:
    - latch src_ptr=SRC, dst_ptr=DST, count=LEN, op=OP;
    - latch buf=FILL_VAL when OP=1;
    - go to FINISH if LEN==0;
    - otherwise go to READ (copy) or WRITE (fill).
- **READ** (copy only)
  - Outputs are MEM_ADDR=src_ptr and MEM_CE=0.
  - At the edge, buf<=MEM_DATA_OUT and src_ptr<=src_ptr+1.
  - Next state is WRITE.
- **WRITE**
  - Outputs are MEM_ADDR=dst_ptr, MEM_DATA_IN=buf, MEM_CE=1. The RAM commits the word on the leaving edge.
  - At that edge, dst_ptr<=dst_ptr+1 and count<=count-1.
  - If count was 1, go to FINISH.
  - Otherwise go to READ (copy) or stay in WRITE (fill).
- **FINISH**: DONE=1, MEM_CE=0, next state IDLE.
- Pointers wrap modulo 2^ADDR_WIDTH. LEN up to 2^(ADDR_WIDTH+1)-1 is legal; addresses wrap.
- Copy is strictly forward, word by word. An overlapping copy with DST>SRC replicates the source pattern; this is the defined behaviour.
- START outside IDLE, including in FINISH, is ignored and not queued.
- Input changes after the START cycle have no effect.

## Timing
- Reset values: state IDLE; BUSY, DONE, MEM_CE = 0; MEM_ADDR, MEM_DATA_IN = 0; pointers, count, buf = 0.
- Take START sampled at edge 0:
  - copy of N words: BUSY high for cycles 1..2N, DONE in cycle 2N+1;
  - fill of N words: BUSY high for cycles 1..N, DONE in cycle N+1;
  - LEN=0: DONE in cycle 1, no MEM_CE.
- The earliest new START is accepted the cycle after DONE, i.e. in IDLE.
- RST=1 at any edge:
  - state returns to IDLE and MEM_CE is 0 after that edge;
  - a WRITE state present during the RST edge still commits, because the RAM samples the same edge;
  - words already written remain; no DONE pulse is produced.

## Configuration
- RAM_DMA_ABORT_EN
- **When defined**: adds input ABORT (1 bit).
  - ABORT=1 sampled in READ or WRITE forces next state FINISH, giving a normal one-cycle DONE.
  - A WRITE cycle in which ABORT is sampled still commits its word.
  - ABORT is ignored in IDLE and FINISH.
  - ABORT has priority over START-independent transitions; RST has priority over ABORT.
- **When undefined**: the ABORT port does not exist and every transfer runs to completion.

## Test plan
- RAM[0x10..0x13]=A1,B2,C3,D4; copy SRC=0x10, DST=0x40, LEN=4 -> RAM[0x40..0x43]=A1,B2,C3,D4; BUSY for 8 cycles; DONE in cycle 9; source unchanged.
- Fill DST=0xFE, LEN=4, FILL_VAL=0x5A -> RAM[0xFE], RAM[0xFF], RAM[0x00], RAM[0x01]=0x5A (wrap); DONE in cycle 5.
- LEN=0 copy -> DONE in cycle 1, MEM_CE never high, RAM unchanged.
- RAM[0x20]=11, RAM[0x21]=22; copy SRC=0x20, DST=0x21, LEN=3 -> RAM[0x21..0x23]=11,11,11.
- START pulsed during a running fill; RST asserted in the 2nd WRITE of a fill LEN=5 at DST=0x80 -> second START ignored; RAM[0x80..0x81] written, RAM[0x82..0x84] untouched; outputs at reset values next cycle; no DONE.
- With RAM_DMA_ABORT_EN: copy LEN=6, ABORT in the 3rd WRITE -> exactly 3 words copied; DONE the following cycle.
